// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle between a word source and serial_frame_tx.
// The source uses the master modport and the transmitter uses the slave modport.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] DATA_i;
  logic              VALID_i;
  logic              READY_o;
  logic              TX_o;
  logic              BUSY_o;
  logic              DONE_o;

  modport master (
    output DATA_i, VALID_i,
    input  READY_o, TX_o, BUSY_o, DONE_o
  );

  modport slave (
    input  DATA_i, VALID_i,
    output READY_o, TX_o, BUSY_o, DONE_o
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, stop bit, CLK_DIV clocks per bit.
// Define PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module serial_frame_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             C_i,
  input  logic             nR_i,
  serial_frame_tx_if.slave bus
);
  localparam int TW = $clog2(CLK_DIV) + 1;
  localparam int IW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state, w_state_next;
  logic [TW-1:0]     r_timer, w_timer_next;
  logic [IW-1:0]     r_idx, w_idx_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic              r_tx, w_tx_next;
  logic              r_ready, w_ready_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              w_accept, w_bit_end, w_last_bit;
`ifdef PARITY_EN
  logic              r_parity;
`endif

  assign w_accept   = bus.VALID_i & r_ready;
  assign w_bit_end  = (r_timer == TW'(CLK_DIV - 1));
  assign w_last_bit = (r_idx == IW'(DATA_W - 1));

  assign bus.TX_o    = r_tx;
  assign bus.READY_o = r_ready;
  assign bus.BUSY_o  = r_busy;
  assign bus.DONE_o  = r_done;

  always_ff @(posedge C_i) begin
    if (!nR_i) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_ready  <= w_ready_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
`ifdef PARITY_EN
      if (r_state == S_IDLE && w_accept) begin
        r_parity <= ^bus.DATA_i;
      end
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_START;
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && w_last_bit) begin
`ifdef PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level is decoded from the state being entered so every output stays registered.
  always_comb begin
    w_timer_next = r_timer;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_timer_next = '0;
        w_idx_next   = '0;
        w_shift_next = bus.DATA_i;
      end
    end else begin
      w_timer_next = w_bit_end ? '0 : r_timer + TW'(1);
      if (r_state == S_DATA && w_bit_end) begin
        w_shift_next = r_shift >> 1;
        w_idx_next   = r_idx + IW'(1);
      end
    end

    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase

    w_ready_next = (w_state_next == S_IDLE);
    w_busy_next  = (w_state_next != S_IDLE);
    w_done_next  = (r_state == S_STOP) && (w_state_next == S_IDLE);
  end
endmodule
